// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage enable/clear controller for a dual-issue pipeline.
// Arbitrates exceptions, memory stalls, divide waits, load-use hazards and
// branch flushes into per-stage enable/clear strobes. All strobes are
// combinational from the current state and current inputs.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cnt/flush_cnt
// performance counters and their ports.
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] d_master_rs,
    input  logic [4:0] d_master_rt,
    input  logic [4:0] d_slave_rs,
    input  logic [4:0] d_slave_rt,
    input  logic       d_slave_issue,
    input  logic       e_master_memRead,
    input  logic [4:0] e_master_reg_waddr,
    input  logic       e_slave_memtoReg,
    input  logic [4:0] e_slave_reg_waddr,
    input  logic       e_div_start,
    input  logic       div_done,
    input  logic       i_stall,
    input  logic       d_stall,
    input  logic       exception,
    input  logic       branch_flush,
    output logic       f_ena,
    output logic       d_ena,
    output logic       d_clear,
    output logic       e_ena1,
    output logic       e_clear1,
    output logic       e_ena2,
    output logic       e_clear2,
    output logic       m_ena,
    output logic       m_clear,
    output logic       w_ena,
    output logic       busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    // Bit order: f_ena d_ena d_clear e_ena1 e_clear1 e_ena2 e_clear2 m_ena m_clear w_ena
    typedef struct packed {
        logic f_ena;
        logic d_ena;
        logic d_clear;
        logic e_ena1;
        logic e_clear1;
        logic e_ena2;
        logic e_clear2;
        logic m_ena;
        logic m_clear;
        logic w_ena;
    } ctl_t;

    // Reset: nothing advances, every stage register is cleared.
    localparam ctl_t CTL_RESET    = 10'b0010101010;
    // Memory stall: freeze the whole pipeline, no bubbles injected.
    localparam ctl_t CTL_FREEZE   = 10'b0000000000;
    // Exception/eret: keep fetching the handler, squash D, E and M.
    localparam ctl_t CTL_FLUSH    = 10'b1111111111;
    // Divide in progress: hold F/D/E, feed a bubble into M, let W retire.
    localparam ctl_t CTL_DIV_HOLD = 10'b0000000111;
    // Load-use: hold F/D, bubble both E slots, M and W keep moving.
    localparam ctl_t CTL_LOAD_USE = 10'b0001111101;
    // Normal dual-issue advance.
    localparam ctl_t CTL_NORMAL   = 10'b1101010101;

    // Normal advance; the slave E slot gets a bubble when decode single-issues.
    function automatic ctl_t ctl_normal(input logic slave_issue);
        ctl_t c;
        c          = CTL_NORMAL;
        c.e_clear2 = ~slave_issue;
        return c;
    endfunction

    // True when a nonzero E-stage destination feeds a live D-stage source.
    function automatic logic src_match(input logic [4:0] waddr,
                                       input logic [4:0] m_rs,
                                       input logic [4:0] m_rt,
                                       input logic [4:0] s_rs,
                                       input logic [4:0] s_rt,
                                       input logic       s_issue);
        logic hit;
        hit = (waddr == m_rs) || (waddr == m_rt) ||
              (s_issue && ((waddr == s_rs) || (waddr == s_rt)));
        return (waddr != 5'd0) && hit;
    endfunction

    state_t state_r;
    state_t state_nxt_s;
    logic   div_pend_r;      // a divide was in flight when MEM_WAIT was entered
    logic   div_pend_nxt_s;
    logic   done_seen_r;     // div_done observed while frozen in MEM_WAIT
    logic   done_seen_nxt_s;
    logic   mem_stall_s;
    logic   load_use_s;
    logic   run_to_div_s;
    ctl_t   run_ctl_s;
    ctl_t   ctl_s;

    assign mem_stall_s = i_stall | d_stall;

    assign load_use_s =
        (e_master_memRead && src_match(e_master_reg_waddr, d_master_rs, d_master_rt,
                                       d_slave_rs, d_slave_rt, d_slave_issue)) ||
        (e_slave_memtoReg && src_match(e_slave_reg_waddr, d_master_rs, d_master_rt,
                                       d_slave_rs, d_slave_rt, d_slave_issue));

    // RUN-state strobes for the no-stall case: divide start > load-use > branch > normal.
    always_comb begin
        run_ctl_s    = ctl_normal(d_slave_issue);
        run_to_div_s = 1'b0;
        if (e_div_start) begin
            run_ctl_s    = CTL_DIV_HOLD;
            run_to_div_s = 1'b1;
        end else if (load_use_s) begin
            run_ctl_s = CTL_LOAD_USE;
        end else if (branch_flush) begin
            run_ctl_s         = ctl_normal(d_slave_issue);
            run_ctl_s.d_clear = 1'b1;
        end else begin
            run_ctl_s = ctl_normal(d_slave_issue);
        end
    end

    // Next-state, divide bookkeeping and stage strobes; reset and exception override every state.
    always_comb begin
        ctl_s           = CTL_RESET;
        state_nxt_s     = state_r;
        div_pend_nxt_s  = div_pend_r;
        done_seen_nxt_s = done_seen_r;
        if (rst) begin
            ctl_s           = CTL_RESET;
            state_nxt_s     = RUN;
            div_pend_nxt_s  = 1'b0;
            done_seen_nxt_s = 1'b0;
        end else if (exception) begin
            ctl_s           = CTL_FLUSH;
            state_nxt_s     = FLUSH;
            div_pend_nxt_s  = 1'b0;
            done_seen_nxt_s = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_stall_s) begin
                        ctl_s           = CTL_FREEZE;
                        state_nxt_s     = MEM_WAIT;
                        div_pend_nxt_s  = 1'b0;
                        done_seen_nxt_s = 1'b0;
                    end else if (run_to_div_s) begin
                        ctl_s       = run_ctl_s;
                        state_nxt_s = DIV_WAIT;
                    end else begin
                        ctl_s       = run_ctl_s;
                        state_nxt_s = RUN;
                    end
                end
                DIV_WAIT: begin
                    if (mem_stall_s) begin
                        // A done arriving on the entry cycle must not be lost.
                        ctl_s           = CTL_FREEZE;
                        state_nxt_s     = MEM_WAIT;
                        div_pend_nxt_s  = 1'b1;
                        done_seen_nxt_s = div_done;
                    end else if (div_done) begin
                        ctl_s       = ctl_normal(d_slave_issue);
                        state_nxt_s = RUN;
                    end else begin
                        ctl_s       = CTL_DIV_HOLD;
                        state_nxt_s = DIV_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall_s) begin
                        ctl_s           = CTL_FREEZE;
                        done_seen_nxt_s = done_seen_r | div_done;
                    end else if (div_pend_r && !(done_seen_r || div_done)) begin
                        ctl_s           = CTL_DIV_HOLD;
                        state_nxt_s     = DIV_WAIT;
                        div_pend_nxt_s  = 1'b0;
                        done_seen_nxt_s = 1'b0;
                    end else if (div_pend_r) begin
                        // Divide finished under the stall: let E advance now.
                        ctl_s           = ctl_normal(d_slave_issue);
                        state_nxt_s     = RUN;
                        div_pend_nxt_s  = 1'b0;
                        done_seen_nxt_s = 1'b0;
                    end else begin
                        ctl_s           = run_ctl_s;
                        state_nxt_s     = run_to_div_s ? DIV_WAIT : RUN;
                        done_seen_nxt_s = 1'b0;
                    end
                end
                FLUSH: begin
                    ctl_s       = CTL_FLUSH;
                    state_nxt_s = RUN;
                end
                default: begin
                    ctl_s       = CTL_RESET;
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    // State register and divide-tracking flags.
    always_ff @(posedge clk) begin
        state_r     <= state_nxt_s;
        div_pend_r  <= div_pend_nxt_s;
        done_seen_r <= done_seen_nxt_s;
    end

    assign f_ena    = ctl_s.f_ena;
    assign d_ena    = ctl_s.d_ena;
    assign d_clear  = ctl_s.d_clear;
    assign e_ena1   = ctl_s.e_ena1;
    assign e_clear1 = ctl_s.e_clear1;
    assign e_ena2   = ctl_s.e_ena2;
    assign e_clear2 = ctl_s.e_clear2;
    assign m_ena    = ctl_s.m_ena;
    assign m_clear  = ctl_s.m_clear;
    assign w_ena    = ctl_s.w_ena;
    assign busy     = (state_r != RUN);

`ifdef PIPE_CTRL_PERF_EN
    logic rst_q_r;

    // Previous-cycle reset, so a sustained reset can be told apart from a single pulse.
    always_ff @(posedge clk) begin
        rst_q_r <= rst;
    end

    // Counters freeze on any reset cycle and clear once reset is held a second cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (rst_q_r) begin
                stall_cnt <= 32'd0;
                flush_cnt <= 32'd0;
            end else begin
                stall_cnt <= stall_cnt;
                flush_cnt <= flush_cnt;
            end
        end else begin
            if (!ctl_s.f_ena) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (exception || branch_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus a randomized run against a
// flag-based behavioural model of the pipeline controller.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] d_master_rs, d_master_rt, d_slave_rs, d_slave_rt;
    logic       d_slave_issue;
    logic       e_master_memRead;
    logic [4:0] e_master_reg_waddr;
    logic       e_slave_memtoReg;
    logic [4:0] e_slave_reg_waddr;
    logic       e_div_start, div_done, i_stall, d_stall, exception, branch_flush;
    logic       f_ena, d_ena, d_clear, e_ena1, e_clear1, e_ena2, e_clear2;
    logic       m_ena, m_clear, w_ena, busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .d_master_rs(d_master_rs), .d_master_rt(d_master_rt),
        .d_slave_rs(d_slave_rs), .d_slave_rt(d_slave_rt),
        .d_slave_issue(d_slave_issue),
        .e_master_memRead(e_master_memRead), .e_master_reg_waddr(e_master_reg_waddr),
        .e_slave_memtoReg(e_slave_memtoReg), .e_slave_reg_waddr(e_slave_reg_waddr),
        .e_div_start(e_div_start), .div_done(div_done),
        .i_stall(i_stall), .d_stall(d_stall),
        .exception(exception), .branch_flush(branch_flush),
        .f_ena(f_ena), .d_ena(d_ena), .d_clear(d_clear),
        .e_ena1(e_ena1), .e_clear1(e_clear1), .e_ena2(e_ena2), .e_clear2(e_clear2),
        .m_ena(m_ena), .m_clear(m_clear), .w_ena(w_ena), .busy(busy)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // {f_ena, d_ena, d_clear, e_ena1, e_clear1, e_ena2, e_clear2, m_ena, m_clear, w_ena}
    logic [9:0] obs;
    assign obs = {f_ena, d_ena, d_clear, e_ena1, e_clear1, e_ena2, e_clear2, m_ena, m_clear, w_ena};

    localparam logic [9:0] EXP_RST   = 10'b0010101010;
    localparam logic [9:0] EXP_HOLD  = 10'b0000000000;
    localparam logic [9:0] EXP_EXC   = 10'b1111111111;
    localparam logic [9:0] EXP_DIV   = 10'b0000000111;
    localparam logic [9:0] EXP_LU    = 10'b0001111101;

    function automatic logic [9:0] exp_normal(input logic si);
        return si ? 10'b1101010101 : 10'b1101011101;
    endfunction

    function automatic logic [9:0] exp_branch(input logic si);
        return exp_normal(si) | 10'b0010000000;
    endfunction

    task automatic set_idle();
        rst = 1'b0;
        d_master_rs = 5'd0; d_master_rt = 5'd0; d_slave_rs = 5'd0; d_slave_rt = 5'd0;
        d_slave_issue = 1'b1;
        e_master_memRead = 1'b0; e_master_reg_waddr = 5'd0;
        e_slave_memtoReg = 1'b0; e_slave_reg_waddr = 5'd0;
        e_div_start = 1'b0; div_done = 1'b0; i_stall = 1'b0; d_stall = 1'b0;
        exception = 1'b0; branch_flush = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            set_idle();
            rst = (c < 3) ? 1'b1 : 1'b0;
            #1;
            vectors++;
            if (obs !== ((c < 3) ? EXP_RST : exp_normal(1'b1))) begin
                miscompares++;
                $display("FAIL reset_ctl c%0d: got %b want %b", c, obs,
                         (c < 3) ? EXP_RST : exp_normal(1'b1));
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_busy c%0d: got %b want 0", c, busy);
            end
`ifdef PIPE_CTRL_PERF_EN
            if (c == 3) begin
                vectors++;
                if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
                    miscompares++;
                    $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
                end
            end
`endif
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        logic [9:0] want [3];
        want[0] = EXP_LU; want[1] = exp_normal(1'b1); want[2] = exp_normal(1'b1);
        for (int c = 0; c < 3; c++) begin
            set_idle();
            if (c == 0) begin
                e_master_memRead = 1'b1; e_master_reg_waddr = 5'd5; d_master_rs = 5'd5;
            end else if (c == 2) begin
                e_master_memRead = 1'b1; e_master_reg_waddr = 5'd0; d_master_rs = 5'd0;
            end
            #1;
            vectors++;
            if (obs !== want[c] || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL load_use c%0d: got %b busy %b want %b busy 0", c, obs, busy, want[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_divide();
        int busy_cycles = 0;
        logic [9:0] want;
        for (int c = 0; c <= 11; c++) begin
            set_idle();
            e_div_start = (c == 0);
            div_done = (c == 10);
            #1;
            want = (c >= 10) ? exp_normal(1'b1) : EXP_DIV;
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL divide_ctl c%0d: got %b want %b", c, obs, want);
            end
            if (busy === 1'b1) busy_cycles++;
            vectors++;
            if (busy !== (c >= 1 && c <= 10)) begin
                miscompares++;
                $display("FAIL divide_busy c%0d: got %b want %b", c, busy, (c >= 1 && c <= 10));
            end
            next_cycle();
        end
        vectors++;
        if (busy_cycles != 10) begin
            miscompares++;
            $display("FAIL divide_busy_len: got %0d want 10", busy_cycles);
        end
    endtask

    task automatic test_mem_in_div();
        logic [9:0] want;
        logic       want_busy;
        for (int c = 0; c <= 7; c++) begin
            set_idle();
            e_div_start = (c == 0);
            d_stall = (c >= 3 && c <= 5);
            div_done = (c == 4);
            #1;
            if (c <= 2) want = EXP_DIV;
            else if (c <= 5) want = EXP_HOLD;
            else want = exp_normal(1'b1);
            want_busy = (c >= 1 && c <= 6);
            vectors++;
            if (obs !== want || busy !== want_busy) begin
                miscompares++;
                $display("FAIL mem_in_div c%0d: got %b busy %b want %b busy %b",
                         c, obs, busy, want, want_busy);
            end
            next_cycle();
        end
    endtask

    task automatic test_exc_in_mem();
        logic [9:0]  want;
        logic        want_busy;
        logic [31:0] fc0;
        fc0 = 32'd0;
        for (int c = 0; c <= 4; c++) begin
            set_idle();
            i_stall = (c <= 2);
            exception = (c == 2);
            #1;
            if (c <= 1) want = EXP_HOLD;
            else if (c <= 3) want = EXP_EXC;
            else want = exp_normal(1'b1);
            want_busy = (c >= 1 && c <= 3);
            vectors++;
            if (obs !== want || busy !== want_busy) begin
                miscompares++;
                $display("FAIL exc_in_mem c%0d: got %b busy %b want %b busy %b",
                         c, obs, busy, want, want_busy);
            end
`ifdef PIPE_CTRL_PERF_EN
            if (c == 2) fc0 = flush_cnt;
            if (c == 3) begin
                vectors++;
                if (flush_cnt !== fc0 + 32'd1) begin
                    miscompares++;
                    $display("FAIL exc_flush_cnt: got %0d want %0d", flush_cnt, fc0 + 32'd1);
                end
            end
`endif
            next_cycle();
        end
        if (fc0 != 32'd0) fc0 = 32'd0;
    endtask

    task automatic test_single_branch();
        set_idle();
        d_slave_issue = 1'b0;
        #1;
        vectors++;
        if (e_clear2 !== 1'b1 || e_clear1 !== 1'b0 || obs !== exp_normal(1'b0)) begin
            miscompares++;
            $display("FAIL single_issue: got %b want %b", obs, exp_normal(1'b0));
        end
        next_cycle();
        set_idle();
        branch_flush = 1'b1;
        #1;
        vectors++;
        if (d_clear !== 1'b1 || f_ena !== 1'b1 || obs !== exp_branch(1'b1)) begin
            miscompares++;
            $display("FAIL branch_flush: got %b want %b", obs, exp_branch(1'b1));
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_div();
        logic [9:0]  want;
        logic        want_busy;
        logic [31:0] sc0;
        sc0 = 32'd0;
        for (int c = 0; c <= 3; c++) begin
            set_idle();
            e_div_start = (c == 0);
            rst = (c == 2);
            #1;
            if (c <= 1) want = EXP_DIV;
            else if (c == 2) want = EXP_RST;
            else want = exp_normal(1'b1);
            want_busy = (c == 1 || c == 2);
            vectors++;
            if (obs !== want || busy !== want_busy) begin
                miscompares++;
                $display("FAIL reset_mid_div c%0d: got %b busy %b want %b busy %b",
                         c, obs, busy, want, want_busy);
            end
`ifdef PIPE_CTRL_PERF_EN
            if (c == 2) sc0 = stall_cnt;
            if (c == 3) begin
                vectors++;
                if (stall_cnt !== sc0) begin
                    miscompares++;
                    $display("FAIL reset_stall_cnt: got %0d want %0d", stall_cnt, sc0);
                end
            end
`endif
            next_cycle();
        end
        if (sc0 != 32'd0) sc0 = 32'd0;
    endtask

    // Randomized run against a model built from the priority rules with plain flags.
    task automatic test_random();
        bit          in_div, in_mem, in_flush, pend, seen, prev_rst;
        bit          lu, stall;
        logic [9:0]  want;
        logic [31:0] m_stall_cnt, m_flush_cnt;
        logic [4:0]  srcs [$];
        in_div = 0; in_mem = 0; in_flush = 0; pend = 0; seen = 0; prev_rst = 0;
        m_stall_cnt = 32'd0; m_flush_cnt = 32'd0;
        // Two reset cycles bring DUT and model to a common origin.
        for (int c = 0; c < 2; c++) begin
            set_idle();
            rst = 1'b1;
            #1;
            next_cycle();
        end
        prev_rst = 1;
        for (int n = 0; n < 600; n++) begin
            set_idle();
            rst                = ($urandom_range(0, 39) == 0);
            d_master_rs        = 5'($urandom_range(0, 3));
            d_master_rt        = 5'($urandom_range(0, 3));
            d_slave_rs         = 5'($urandom_range(0, 3));
            d_slave_rt         = 5'($urandom_range(0, 3));
            d_slave_issue      = ($urandom_range(0, 3) != 0);
            e_master_memRead   = ($urandom_range(0, 3) == 0);
            e_master_reg_waddr = 5'($urandom_range(0, 3));
            e_slave_memtoReg   = ($urandom_range(0, 4) == 0);
            e_slave_reg_waddr  = 5'($urandom_range(0, 3));
            e_div_start        = ($urandom_range(0, 9) == 0);
            div_done           = ($urandom_range(0, 4) == 0);
            i_stall            = ($urandom_range(0, 9) == 0);
            d_stall            = ($urandom_range(0, 9) == 0);
            exception          = ($urandom_range(0, 29) == 0);
            branch_flush       = ($urandom_range(0, 5) == 0);
            #1;
            srcs = {d_master_rs, d_master_rt};
            if (d_slave_issue) begin
                srcs.push_back(d_slave_rs);
                srcs.push_back(d_slave_rt);
            end
            lu = 0;
            foreach (srcs[k]) begin
                if (e_master_memRead && e_master_reg_waddr != 5'd0 && srcs[k] == e_master_reg_waddr) lu = 1;
                if (e_slave_memtoReg && e_slave_reg_waddr != 5'd0 && srcs[k] == e_slave_reg_waddr) lu = 1;
            end
            stall = i_stall || d_stall;

            vectors++;
            if (busy !== (in_div || in_mem || in_flush)) begin
                miscompares++;
                $display("FAIL rand_busy n%0d: got %b want %b", n, busy, (in_div || in_mem || in_flush));
            end
`ifdef PIPE_CTRL_PERF_EN
            vectors++;
            if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
                miscompares++;
                $display("FAIL rand_cnt n%0d: got %0d/%0d want %0d/%0d",
                         n, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
            end
`endif
            if (rst) begin
                want = EXP_RST;
                in_div = 0; in_mem = 0; in_flush = 0; pend = 0; seen = 0;
            end else if (exception) begin
                want = EXP_EXC;
                in_div = 0; in_mem = 0; in_flush = 1; pend = 0; seen = 0;
            end else if (in_flush) begin
                want = EXP_EXC;
                in_flush = 0;
            end else if (in_mem && stall) begin
                want = EXP_HOLD;
                seen = seen || div_done;
            end else if (in_mem && pend && !(seen || div_done)) begin
                want = EXP_DIV;
                in_mem = 0; in_div = 1; pend = 0; seen = 0;
            end else if (in_mem && pend) begin
                want = exp_normal(d_slave_issue);
                in_mem = 0; pend = 0; seen = 0;
            end else if (in_div && stall) begin
                want = EXP_HOLD;
                in_div = 0; in_mem = 1; pend = 1; seen = div_done;
            end else if (in_div) begin
                want = div_done ? exp_normal(d_slave_issue) : EXP_DIV;
                in_div = !div_done;
            end else if (!in_mem && stall) begin
                want = EXP_HOLD;
                in_mem = 1; pend = 0; seen = 0;
            end else begin
                // RUN, or leaving a plain memory stall: ordinary issue rules apply.
                in_mem = 0; seen = 0;
                if (e_div_start) begin
                    want = EXP_DIV;
                    in_div = 1;
                end else if (lu) begin
                    want = EXP_LU;
                end else if (branch_flush) begin
                    want = exp_branch(d_slave_issue);
                end else begin
                    want = exp_normal(d_slave_issue);
                end
            end
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL rand_ctl n%0d: got %b want %b", n, obs, want);
            end
            if (rst) begin
                if (prev_rst) begin
                    m_stall_cnt = 32'd0;
                    m_flush_cnt = 32'd0;
                end
            end else begin
                if (!want[9]) m_stall_cnt = m_stall_cnt + 32'd1;
                if (exception || branch_flush) m_flush_cnt = m_flush_cnt + 32'd1;
            end
            prev_rst = rst;
            next_cycle();
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_load_use();
        test_divide();
        test_mem_in_div();
        test_exc_in_mem();
        test_single_branch();
        test_reset_mid_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
